adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 116 +++++++++++
 tb/tb_adder_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared fixed-latency adder, with a credit-guarded result FIFO.
// Define ADDER_ARBITER_PARITY_EN to add rsp_odd (LSB of the stored sum) to the response port.
module adder_arbiter #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*W-1:0]         req_a,
  input  logic [N*W-1:0]         req_b,
  output logic [N-1:0]           req_ready,
  output logic [W-1:0]           add_a,
  output logic [W-1:0]           add_b,
  input  logic [W:0]             add_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [W:0]             rsp_sum,
  output logic [$clog2(N)-1:0]   rsp_id
`ifdef ADDER_ARBITER_PARITY_EN
  ,
  output logic                   rsp_odd
`endif
);

  localparam int IW = $clog2(N);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] ptr;
  logic [LAT-1:0] tag_v;
  logic [IW-1:0] tag_id [LAT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, inflight;
  logic [W:0]    mem_sum [DEPTH];
  logic [IW-1:0] mem_id [DEPTH];
`ifdef ADDER_ARBITER_PARITY_EN
  logic          mem_odd [DEPTH];
`endif

  logic          gnt_found;
  logic [IW-1:0] gnt_id;
  logic [IW:0]   cand;
  logic [IW-1:0] idx;
  logic [CW:0]   used;
  logic          credit, grant, wr_en, pop;

  // First valid requester at or after ptr, wrapping modulo N (N need not be a power of two).
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      idx = cand[IW-1:0];
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  // Credit covers both buffered and still-in-the-adder results, so the FIFO can never overflow.
  assign used      = {1'b0, count} + {1'b0, inflight};
  assign credit    = used < (CW+1)'(DEPTH);
  assign grant     = rst_n && gnt_found && credit;
  assign req_ready = grant ? (N'(1) << gnt_id) : '0;
  assign add_a     = grant ? req_a[gnt_id*W +: W] : '0;
  assign add_b     = grant ? req_b[gnt_id*W +: W] : '0;

  assign wr_en     = tag_v[LAT-1];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_sum   = rsp_valid ? mem_sum[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;
`ifdef ADDER_ARBITER_PARITY_EN
  assign rsp_odd   = rsp_valid ? mem_odd[rd_ptr] : 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      tag_v    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      if (grant) ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
      tag_v[0] <= grant;
      for (int k = 1; k < LAT; k++) tag_v[k] <= tag_v[k-1];
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(wr_en) - CW'(pop);
      inflight <= inflight + CW'(grant) - CW'(wr_en);
    end
  end

  // Tag ids and FIFO payload are qualified by tag_v / count, so they need no reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
    if (wr_en) begin
      mem_sum[wr_ptr] <= add_sum;
      mem_id[wr_ptr]  <= tag_id[LAT-1];
`ifdef ADDER_ARBITER_PARITY_EN
      mem_odd[wr_ptr] <= add_sum[0];
`endif
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: models the external LAT-stage adder and checks
// arbitration order, result timing, carry, backpressure credit and mid-flight reset.
module tb_adder_arbiter;
  localparam int W = 8, N = 4, LAT = 2, DEPTH = 4;

  logic           clk, rst_n;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b;
  logic [W:0]     add_sum;
  logic           rsp_valid, rsp_ready;
  logic [W:0]     rsp_sum;
  logic [1:0]     rsp_id;
`ifdef ADDER_ARBITER_PARITY_EN
  logic           rsp_odd;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adder_arbiter #(.W(W), .N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id)
`ifdef ADDER_ARBITER_PARITY_EN
    , .rsp_odd(rsp_odd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: LAT registers from operand capture to add_sum.
  logic [W:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  logic [8:0] exp_sum [4];
  logic [3:0] one_hot;

  initial begin
    exp_sum[0] = 9'h011; exp_sum[1] = 9'h022; exp_sum[2] = 9'h033; exp_sum[3] = 9'h044;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Outputs held at zero during reset even with requests present.
    #2;
    req_valid = 4'hF;
    set_op(0, 8'h12, 8'h34);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_add_a", 32'(add_a), 32'h0);
    chk("rst_add_b", 32'(add_b), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Single request, transfer on the first edge after release.
    set_op(0, 8'h05, 8'h03);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_add_a", 32'(add_a), 32'h05);
    chk("single_add_b", 32'(add_b), 32'h03);
    tick();
    req_valid = '0;
    chk("single_lat1", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_lat2", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_sum", 32'(rsp_sum), 32'h008);
    chk("single_id", 32'(rsp_id), 32'h0);
    tick();
    chk("single_popped", 32'(rsp_valid), 32'h0);

    // Carry-out on requester 3 (ptr is 1, so the search wraps past 1 and 2 to 3).
    set_op(3, 8'hFF, 8'h01);
    req_valid = 4'b1000;
    #1;
    chk("carry_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick(); tick();
    chk("carry_valid", 32'(rsp_valid), 32'h1);
    chk("carry_sum", 32'(rsp_sum), 32'h100);
    chk("carry_id", 32'(rsp_id), 32'h3);
`ifdef ADDER_ARBITER_PARITY_EN
    chk("carry_odd", 32'(rsp_odd), 32'h0);
`endif
    tick();
    chk("carry_popped", 32'(rsp_valid), 32'h0);

    // Fairness: all four requesting for 8 cycles, ptr starts at 0.
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h10 * (i + 1)), 8'(i + 1));
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      one_hot = 4'b0001 << (c % 4);
      chk("fair_ready", 32'(req_ready), (c < 8) ? 32'(one_hot) : 32'h0);
      if (c >= 3 && c < 11) begin
        chk("fair_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("fair_rsp_id", 32'(rsp_id), 32'((c - 3) % 4));
        chk("fair_rsp_sum", 32'(rsp_sum), 32'(exp_sum[(c - 3) % 4]));
      end else begin
        chk("fair_rsp_idle", 32'(rsp_valid), 32'h0);
      end
      tick();
    end

    // Backpressure: exactly DEPTH transfers, then one pop buys exactly one grant.
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 4'hF;
      #1;
      one_hot = 4'b0001 << c;
      chk("bp_ready", 32'(req_ready), (c < 4) ? 32'(one_hot) : 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_full_ready", 32'(req_ready), 32'h0);
    chk("bp_head_valid", 32'(rsp_valid), 32'h1);
    chk("bp_head_id", 32'(rsp_id), 32'h0);
    chk("bp_head_sum", 32'(rsp_sum), 32'h011);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_regrant", 32'(req_ready), 32'h1);
    chk("bp_regrant_a", 32'(add_a), 32'h10);
    tick();
    chk("bp_refull", 32'(req_ready), 32'h0);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_drain_valid", 32'(rsp_valid), 32'h1);
      chk("bp_drain_id", 32'(rsp_id), 32'((c + 1) % 4));
      chk("bp_drain_sum", 32'(rsp_sum), 32'(exp_sum[(c + 1) % 4]));
      tick();
    end
    chk("bp_empty", 32'(rsp_valid), 32'h0);

    // Reset one cycle after two transfers (r1, r2; ptr would become 3).
    req_valid = 4'b0110;
    #1;
    chk("mid_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("mid_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    chk("mid_prereset_valid", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_sum", 32'(rsp_sum), 32'h0);
    chk("mid_rst_id", 32'(rsp_id), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_add_a", 32'(add_a), 32'h0);
    tick(); tick();
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("post_rst_quiet", 32'(rsp_valid), 32'h0);
      tick();
    end
    req_valid = 4'b1001;
    #1;
    chk("post_rst_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
